// File: rtl/obc_da_sequencer_if.sv
// Bundle of frame-input, combiner and result signals for the OBC
// distributed-arithmetic sequencer.
// The master modport is the sequencer itself.
// The slave modport is the environment around it: the frame source, the
// 8-ROM combiner and the result consumer.
interface obc_da_sequencer_if #(
    parameter int DW = 8,
    parameter int AW = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [16*DW-1:0]          in_data;
    logic signed [AW+DW-1:0]   obc_offset;
    logic [15:0]               slice;
    logic                      i_sel;
    logic signed [AW-1:0]      romout;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [AW+DW-1:0]   out_re;
    logic signed [AW+DW-1:0]   out_im;
    logic                      busy;

    modport master (
        input  in_valid, in_data, obc_offset, romout, out_ready,
        output in_ready, slice, i_sel, out_valid, out_re, out_im, busy
    );

    modport slave (
        output in_valid, in_data, obc_offset, romout, out_ready,
        input  in_ready, slice, i_sel, out_valid, out_re, out_im, busy
    );
endinterface

// File: rtl/obc_da_sequencer.sv
// OBC distributed-arithmetic bit-serial sequencer.
// It holds a frame of 16 samples and streams one bit-slice per cycle, MSB
// first, to an external 8-ROM combiner.
// It Horner-accumulates the combiner partial sums: one real pass, then one
// imaginary pass.
// Each pass result adds the offset once and is registered.
// The real and imaginary results are then presented with a valid/ready
// handshake.
module obc_da_sequencer #(
    parameter int DW = 8,
    parameter int AW = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    obc_da_sequencer_if.master bus
);
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;
    localparam int RW = AW + DW;
    localparam logic [BW-1:0] B_TOP = BW'(DW - 1);

    typedef enum logic [1:0] {IDLE, RUN_RE, RUN_IM, DONE} state_t;

    state_t              state_reg;
    logic [16*DW-1:0]    data_reg;
    logic signed [RW-1:0] offset_reg;
    logic [BW-1:0]       b_reg;
    logic signed [RW-1:0] acc_reg;
    logic signed [RW-1:0] out_re_reg;
    logic signed [RW-1:0] out_im_reg;
    logic                i_sel_reg;
    logic                out_valid_reg;

    logic signed [RW-1:0] rom_ext;
    logic signed [RW-1:0] acc_next;
    logic signed [RW-1:0] pass_sum;
    logic [15:0]         slice_bits;
    logic                running;

    assign running = (state_reg == RUN_RE) || (state_reg == RUN_IM);

    // Pick bit b of every held sample to form the slice sent to the combiner.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_slice
            logic [DW-1:0] sample;
            assign sample         = data_reg[gi*DW +: DW];
            assign slice_bits[gi] = sample[b_reg];
        end
    endgenerate

    // Horner step. The MSB slice carries negative weight in two's
    // complement, so the first term is subtracted.
    always_comb begin
        rom_ext  = RW'(bus.romout);
        acc_next = '0;
        if (b_reg == B_TOP) begin
            acc_next = -rom_ext;
        end else begin
            acc_next = (acc_reg <<< 1) + rom_ext;
        end
        pass_sum = acc_next + offset_reg;
    end

    // Control FSM. All datapath registers share this one block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            data_reg      <= '0;
            offset_reg    <= '0;
            b_reg         <= B_TOP;
            acc_reg       <= '0;
            out_re_reg    <= '0;
            out_im_reg    <= '0;
            i_sel_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_reg   <= bus.in_data;
                        offset_reg <= bus.obc_offset;
                        b_reg      <= B_TOP;
                        i_sel_reg  <= 1'b0;
                        state_reg  <= RUN_RE;
                    end
                end
                RUN_RE: begin
                    acc_reg <= acc_next;
                    if (b_reg == '0) begin
                        out_re_reg <= pass_sum;
                        b_reg      <= B_TOP;
                        i_sel_reg  <= 1'b1;
                        state_reg  <= RUN_IM;
                    end else begin
                        b_reg <= b_reg - 1'b1;
                    end
                end
                RUN_IM: begin
                    acc_reg <= acc_next;
                    if (b_reg == '0) begin
                        out_im_reg    <= pass_sum;
                        b_reg         <= B_TOP;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        b_reg <= b_reg - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.slice     = running ? slice_bits : 16'h0000;
    assign bus.i_sel     = i_sel_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_re    = out_re_reg;
    assign bus.out_im    = out_im_reg;
endmodule

// File: tb/tb_obc_da_sequencer.sv
// Self-checking bench for obc_da_sequencer.
// A popcount combiner model drives romout.
// Expected results come from a direct signed sum of the samples, pushed to a
// scoreboard at frame accept and popped at the output handshake.
module tb_obc_da_sequencer;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int W  = AW + DW;

    typedef struct {
        longint re;
        longint im;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Edge counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    obc_da_sequencer_if #(.DW(DW), .AW(AW)) bus();

    obc_da_sequencer #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic signed [AW-1:0] comb_model(input logic [15:0] s, input logic isel);
        int p;
        p = $countones(s);
        return isel ? AW'(-p) : AW'(p);
    endfunction

    assign bus.romout = comb_model(bus.slice, bus.i_sel);

    function automatic longint sample_sum(input logic [16*DW-1:0] d);
        longint s;
        logic [DW-1:0] smp;
        s = 0;
        for (int k = 0; k < 16; k++) begin
            smp = d[k*DW +: DW];
            s += longint'($signed(smp));
        end
        return s;
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [16*DW-1:0] d, input logic signed [W-1:0] off);
        exp_t e;
        longint s;
        s = sample_sum(d);
        e.re = s + longint'(off);
        e.im = -s + longint'(off);
        sb.push_back(e);
        $display("[TB] accept cyc=%0d sum=%0d off=%0d", cyc, s, longint'(off));
    endtask

    // Offer a frame and wait (bounded) for it to be accepted.
    task automatic send(input logic [16*DW-1:0] d, input logic signed [W-1:0] off);
        int n;
        n = 0;
        bus.in_valid   = 1'b1;
        bus.in_data    = d;
        bus.obc_offset = off;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        check("accept_bounded", longint'(n < 100), 1);
        tick();
        accept_cyc = cyc;
        check("busy_after_accept", bus.busy, 1);
        push_exp(d, off);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic wait_valid(input bit chk_lat);
        int n;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            tick();
            n++;
        end
        check("out_valid_seen", bus.out_valid, 1);
        if (chk_lat) check("latency", cyc - accept_cyc, 2 * DW);
    endtask

    task automatic receive();
        exp_t e;
        check("sb_nonempty", longint'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("out_re", longint'(bus.out_re), e.re);
            check("out_im", longint'(bus.out_im), e.im);
        end
        $display("[TB] result cyc=%0d re=%0d im=%0d", cyc, longint'(bus.out_re), longint'(bus.out_im));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("out_valid_fall", bus.out_valid, 0);
        check("in_ready_after_hs", bus.in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_sl [8];
        logic [16*DW-1:0] d;
        logic signed [W-1:0] off;
        int quiet;

        exp_sl = '{16'h0001, 16'h0000, 16'h0000, 16'h0000,
                   16'h0000, 16'h0000, 16'h0000, 16'hFFFE};

        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.obc_offset = '0;
        bus.out_ready  = 1'b0;

        // Reset state.
        repeat (3) tick();
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_slice", bus.slice, 0);
        check("rst_i_sel", bus.i_sel, 0);
        check("rst_out_re", longint'(bus.out_re), 0);
        rst_n = 1'b1;
        tick();

        // out_ready while idle has no effect.
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("idle_out_ready_no_valid", bus.out_valid, 0);
        check("idle_out_ready_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b0;

        // All zero samples, offset 5.
        send({16{8'h00}}, W'(5));
        wait_valid(1'b1);
        check("zero_re_const", longint'(bus.out_re), 5);
        receive();

        // All 0xFF samples, offset 0.
        send({16{8'hFF}}, W'(0));
        wait_valid(1'b1);
        check("ff_re_const", longint'(bus.out_re), -16);
        check("ff_im_const", longint'(bus.out_im), 16);
        receive();

        // Sample0 = 0x80, others 0x01: MSB-first slice sequence.
        send({{15{8'h01}}, 8'h80}, W'(0));
        for (int i = 0; i < DW; i++) begin
            check($sformatf("slice_b%0d", DW - 1 - i), bus.slice, exp_sl[i]);
            check("i_sel_re", bus.i_sel, 0);
            tick();
        end
        check("i_sel_im", bus.i_sel, 1);
        check("slice_im_msb", bus.slice, 16'h0001);
        wait_valid(1'b1);
        check("done_slice_zero", bus.slice, 0);
        check("done_i_sel_hold", bus.i_sel, 1);
        check("mix_re_const", longint'(bus.out_re), -113);
        receive();
        check("idle_slice_zero", bus.slice, 0);
        check("idle_i_sel_hold", bus.i_sel, 1);

        // Random frames.
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 16; k++) d[k*DW +: DW] = DW'($urandom);
            off = W'($urandom_range(0, 400)) - W'(200);
            send(d, off);
            wait_valid(1'b1);
            receive();
        end

        // Back-pressure with a second frame waiting.
        d = '0;
        for (int k = 0; k < 16; k++) d[k*DW +: DW] = DW'($urandom);
        send(d, W'(-7));
        wait_valid(1'b1);
        for (int k = 0; k < 16; k++) d[k*DW +: DW] = DW'(k * 3 - 20);
        bus.in_valid   = 1'b1;
        bus.in_data    = d;
        bus.obc_offset = W'(11);
        for (int i = 0; i < 10; i++) begin
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_valid", bus.out_valid, 1);
            check("bp_re_stable", longint'(bus.out_re), sb[0].re);
            check("bp_im_stable", longint'(bus.out_im), sb[0].im);
            tick();
        end
        receive();
        check("bp_not_accepted_in_done", bus.busy, 0);
        tick();
        check("bp_accept_one_bubble", bus.busy, 1);
        accept_cyc = cyc;
        push_exp(d, W'(11));
        bus.in_valid = 1'b0;
        wait_valid(1'b1);
        receive();

        // Reset in the middle of the imaginary pass aborts the frame.
        for (int k = 0; k < 16; k++) d[k*DW +: DW] = DW'($urandom);
        send(d, W'(3));
        repeat (11) tick();
        check("abort_in_run_im", bus.i_sel, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_slice", bus.slice, 0);
        check("abort_i_sel", bus.i_sel, 0);
        check("abort_out_re_clr", longint'(bus.out_re), 0);
        quiet = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) quiet++;
            tick();
        end
        check("abort_no_output", quiet, 0);
        send({16{8'h01}}, W'(0));
        wait_valid(1'b1);
        check("post_rst_re_const", longint'(bus.out_re), 16);
        receive();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/obc_da_sequencer.md
OBC_DA_SEQUENCER -- requirements
Module: obc_da_sequencer

Interface
REQ-001 Parameter DW, default 8: sample width in bits, two's complement.
REQ-002 Parameter AW, default 32: width of the combiner partial sum romout.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  a frame of 16 samples plus an offset is offered.
REQ-006 in_ready  output  1  the sequencer can accept a frame.
REQ-007 in_data  input  16*DW  packed samples; sample k is in_data[k*DW +: DW].
REQ-008 obc_offset  input  AW+DW  signed OBC offset constant, added once per pass.
REQ-009 slice  output  16  bit-slice to the 8-ROM combiner; slice[k] = current bit of sample k.
REQ-010 i_sel  output  1  combiner sign-select; 0 = real pass, 1 = imaginary pass.
REQ-011 romout  input  AW  signed partial sum from the combiner, combinational from slice and i_sel in the same cycle.
REQ-012 out_valid  output  1  results are available.
REQ-013 out_ready  input  1  the consumer accepts the results.
REQ-014 out_re, out_im  output  AW+DW each  signed real and imaginary results.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, RUN_RE, RUN_IM and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; in every other state it SHALL be 0.
REQ-018 Handshake on in_valid & in_ready SHALL latch in_data into a held sample buffer, latch obc_offset, set bit counter b = DW-1 and go to RUN_RE.
REQ-019 In RUN_RE and RUN_IM, slice[k] SHALL equal bit b of held sample k, one bit per cycle, MSB first.
REQ-020 i_sel SHALL be 0 in RUN_RE and 1 in RUN_IM.
REQ-021 i_sel SHALL hold its last value in IDLE and DONE, and slice SHALL be 0 in IDLE and DONE.
REQ-022 Horner accumulation, signed, AW+DW bits: at b = DW-1, acc = -sext(romout); at each b < DW-1, acc = 2*acc + sext(romout).
REQ-023 At b = 0, the pass result SHALL be acc_final + offset, truncated to AW+DW bits with no saturation.
REQ-024 The RUN_RE result SHALL be registered into out_re; the FSM then reloads b = DW-1 from the held buffer and enters RUN_IM.
REQ-025 The RUN_IM result SHALL be registered into out_im; the FSM then enters DONE.
REQ-026 Each pass SHALL take exactly DW cycles; a frame accepted at edge t SHALL give out_valid = 1 after edge t + 2*DW.
REQ-027 In DONE, out_valid SHALL be 1, and out_re and out_im SHALL be held stable until out_valid & out_ready.
REQ-028 On out_valid & out_ready, the FSM SHALL go to IDLE and out_valid SHALL fall on that edge.
REQ-029 in_valid in DONE SHALL be ignored; a new frame SHALL be accepted in IDLE no earlier than the cycle after output handshake (1 idle bubble).
REQ-030 in_valid and in_data SHALL be ignored while busy; held samples and offset SHALL NOT change mid-frame.
REQ-031 out_ready while not out_valid SHALL have no effect.

Reset
REQ-032 With rst_n = 0 at a clock edge, the block SHALL go to IDLE with out_valid = 0, in_ready = 1, busy = 0, slice = 0, i_sel = 0, b = DW-1.
REQ-033 Reset SHALL also clear acc, out_re, out_im, the held offset and the sample buffer to 0.
REQ-034 Reset asserted during RUN_RE, RUN_IM or DONE SHALL abort the frame with no output handshake; the first post-reset frame SHALL behave as after power-up.

Verification
REQ-035 Bench combiner model: romout = popcount(slice) when i_sel = 0, and -popcount(slice) when i_sel = 1; DW = 8.
REQ-036 All samples 0x00, offset 5 -> out_re = 5 and out_im = 5, with out_valid rising 16 cycles after the accept edge.
REQ-037 All samples 0xFF, offset 0 -> out_re = -16 and out_im = +16.
REQ-038 Sample0 = 0x80, others 0x01, offset 0 -> out_re = -128 + 15 = -113 and out_im = +113; check MSB-first slice sequence 0x0001 then six 0x0000 then 0xFFFE.
REQ-039 Back-pressure: out_ready held 0 for 10 cycles, in_valid held 1 -> outputs stable, in_ready = 0 throughout, and the second frame is accepted exactly 1 cycle after the output handshake.
REQ-040 Reset mid-RUN_IM at cycle 11 -> next edge IDLE, out_valid = 0, no output handshake; the following frame (all 0x01, offset 0) gives out_re = 16.
